// File: rtl/mtl_frame_writer.sv
// Frame-buffer producer: packs an RGB raster stream into 0x00RRGGBB words,
// writes them to the back buffer and swaps the display buffer on the next LCD frame.
module mtl_frame_writer #(
  parameter int          H_ACTIVE   = 800,
  parameter int          V_ACTIVE   = 480,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [19:0] BUF1_BASE  = 20'h80000
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iSTART,
  input  logic        iPIX_VALID,
  input  logic [7:0]  iPIX_R,
  input  logic [7:0]  iPIX_G,
  input  logic [7:0]  iPIX_B,
  output logic        oPIX_READY,
  output logic        oWR_REQ,
  output logic [19:0] oWR_ADDR,
  output logic [31:0] oWR_DATA,
  input  logic        iWR_ACK,
  input  logic        iNEW_FRAME,
  output logic        oDISP_SEL,
  output logic        oBUSY,
  output logic        oFRAME_DONE
);

  localparam longint TOTAL = longint'(H_ACTIVE) * longint'(V_ACTIVE);
  // Counters must be able to hold TOTAL itself, hence >= rather than >.
  localparam int CW = (TOTAL >= 64'd1048576) ? $clog2(TOTAL + 1) : 20;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, FLUSH, SWAP} state_t;

  state_t          state_q;
  logic [CW-1:0]   acnt_q, wcnt_q, wcnt_d;
  logic            back_q, disp_q, done_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic [AW-1:0]   wp_q, rp_q;
  logic [23:0]     mem_q [FIFO_DEPTH];
  logic            full, empty, push, pop;

  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);

  assign oPIX_READY = (state_q == WRITE) && !full && (acnt_q < TOTAL_C);
  assign push       = iPIX_VALID && oPIX_READY;
  assign oWR_REQ    = !empty;
  assign pop        = oWR_REQ && iWR_ACK;

  assign oWR_DATA    = empty ? 32'h0 : {8'h00, mem_q[rp_q]};
  assign oWR_ADDR    = (back_q ? BUF1_BASE : 20'h0) + wcnt_q[19:0];
  assign oBUSY       = (state_q != IDLE);
  assign oDISP_SEL   = disp_q;
  assign oFRAME_DONE = done_q;

  always_comb begin
    wcnt_d = wcnt_q + CW'(pop);
    cnt_d  = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= IDLE;
      acnt_q  <= '0;
      wcnt_q  <= '0;
      back_q  <= 1'b0;
      disp_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wcnt_q <= wcnt_d;
      if (push) acnt_q <= acnt_q + CW'(1);
      case (state_q)
        IDLE: if (iSTART) begin
          state_q <= WRITE;
          acnt_q  <= '0;
          wcnt_q  <= '0;
          back_q  <= ~disp_q;
        end
        WRITE: if (push && (acnt_q == TOTAL_C - CW'(1))) state_q <= FLUSH;
        FLUSH: if (wcnt_d == TOTAL_C) state_q <= SWAP;
        // Only a new-frame pulse sampled while already in SWAP triggers the swap.
        SWAP: if (iNEW_FRAME) begin
          disp_q  <= back_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cnt_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
    end
  end

  // Storage carries no reset; oWR_DATA is masked while the FIFO is empty.
  always_ff @(posedge iCLK) begin
    if (push) mem_q[wp_q] <= {iPIX_R, iPIX_G, iPIX_B};
  end

endmodule
